fb_dac_driver: RTL

- Consumer end of the feedback-calculation output interface. Takes the 15-bit signed correction word (pout), the fb_cond sample window, the dac_clk write request and the DSPoflow flag.
- Produces a saturated, offset-corrected, offset-binary word plus a timed write strobe for the kicker DAC.
- Sits between the per-channel feedback calculation and the DAC pins, one instance per channel.

---
 rtl/fb_dac_pkg.sv | 56 +++++
 rtl/fb_dac_driver_sat_cnt.sv | 40 ++++
 rtl/fb_dac_driver.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/fb_dac_pkg.sv
// Shared types and arithmetic helpers for the feedback-channel DAC drivers.
// Values are carried in a 17-bit signed workspace wide enough for any DAC_W up to 15.
package fb_dac_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STROBE = 2'd2
    } dac_state_e;

    localparam int unsigned CALC_W = 17;

    typedef struct packed {
        logic signed [CALC_W-1:0] val;
        logic                     clip;
    } sat_res_t;

    function automatic logic signed [CALC_W-1:0] fs_max_f(input int unsigned w);
        logic signed [CALC_W-1:0] one_s;
        one_s = 17'sd1;
        return (one_s <<< (w - 32'd1)) - 17'sd1;
    endfunction

    function automatic logic signed [CALC_W-1:0] fs_min_f(input int unsigned w);
        logic signed [CALC_W-1:0] one_s;
        one_s = 17'sd1;
        return -(one_s <<< (w - 32'd1));
    endfunction

    function automatic logic [CALC_W-1:0] midscale_f(input int unsigned w);
        logic [CALC_W-1:0] one_u;
        one_u = 17'd1;
        return one_u << (w - 32'd1);
    endfunction

    // Operands must already be sign-extended to CALC_W; the result is clamped to a w-bit signed range.
    function automatic sat_res_t sat_add_f(input logic signed [CALC_W-1:0] a,
                                           input logic signed [CALC_W-1:0] b,
                                           input int unsigned              w);
        sat_res_t                 res;
        logic signed [CALC_W-1:0] sum;
        sum = a + b;
        if (sum > fs_max_f(w)) begin
            res.val  = fs_max_f(w);
            res.clip = 1'b1;
        end else if (sum < fs_min_f(w)) begin
            res.val  = fs_min_f(w);
            res.clip = 1'b1;
        end else begin
            res.val  = sum;
            res.clip = 1'b0;
        end
        return res;
    endfunction

endpackage

// File: rtl/fb_dac_driver_sat_cnt.sv
// Saturating event counter with synchronous clear (clear has priority over increment).
module sat_cnt
    import fb_dac_pkg::*;
#(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear, saturating increment, or hold.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/fb_dac_driver.sv
// Per-channel kicker DAC driver: captures the feedback correction, saturates and
// offsets it, and presents it in offset binary with a setup-then-strobe write cycle.
module fb_dac_driver
    import fb_dac_pkg::*;
#(
    parameter int unsigned DAC_W     = 14,
    parameter int unsigned SETUP_CYC = 2,
    parameter int unsigned WR_LEN    = 2,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [14:0]      pout,
    input  logic             fb_cond,
    input  logic             dac_clk,
    input  logic             DSPoflow,
    input  logic             fb_en,
    input  logic             store_strb,
    input  logic [DAC_W-1:0] dac_offset,
    input  logic             cnt_clr,
    output logic [DAC_W-1:0] dac_data,
    output logic             dac_wr,
    output logic             sat_flag,
    output logic [CNT_W-1:0] oflow_cnt,
    output logic [CNT_W-1:0] busy_cnt
);

    localparam logic [CALC_W-1:0] MID_V    = midscale_f(DAC_W);
    localparam logic [CALC_W-1:0] FS_MAX_V = fs_max_f(DAC_W);
    localparam logic [CALC_W-1:0] FS_MIN_V = fs_min_f(DAC_W);
    localparam logic [3:0]        SETUP_LAST = 4'(SETUP_CYC - 1);
    localparam logic [3:0]        WR_LAST    = 4'(WR_LEN - 1);

    logic             fb_cond_q, dac_clk_q, store_strb_q;
    logic             fb_rise_s, dac_rise_s, clr_req_s, capture_s, busy_inc_s, oflow_inc_s;

    logic [DAC_W-1:0] pending_q, pending_d;
    logic             pending_sat_q, pending_sat_d;

    dac_state_e       state_q, state_d;
    logic [3:0]       cyc_q, cyc_d;
    logic [DAC_W-1:0] dac_data_q, dac_data_d;
    logic             dac_wr_q, dac_wr_d;
    logic             sat_flag_q, sat_flag_d;

    logic signed [CALC_W-1:0] pout_ext_s, pend_ext_s, off_ext_s;
    sat_res_t                 cap_res_s, out_res_s;

    assign pout_ext_s = {{(CALC_W-15){pout[14]}}, pout};
    assign pend_ext_s = {{(CALC_W-DAC_W){pending_q[DAC_W-1]}}, pending_q};
    assign off_ext_s  = {{(CALC_W-DAC_W){dac_offset[DAC_W-1]}}, dac_offset};

    // Edge detection against last cycle's input levels.
    always_comb begin
        fb_rise_s  = fb_cond & ~fb_cond_q;
        dac_rise_s = dac_clk & ~dac_clk_q;
        clr_req_s  = ~store_strb & store_strb_q;
        capture_s  = fb_en & fb_rise_s;
        oflow_inc_s = capture_s & DSPoflow;
        cap_res_s  = sat_add_f(pout_ext_s, 17'sd0, DAC_W);
        out_res_s  = sat_add_f(pend_ext_s, off_ext_s, DAC_W);
    end

    // Pending word: disable clears it, a capture beats a simultaneous clear request.
    always_comb begin
        pending_d     = pending_q;
        pending_sat_d = pending_sat_q;
        if (!fb_en) begin
            pending_d     = '0;
            pending_sat_d = 1'b0;
        end else if (capture_s) begin
            if (DSPoflow) begin
                pending_d     = pout[14] ? FS_MIN_V[DAC_W-1:0] : FS_MAX_V[DAC_W-1:0];
                pending_sat_d = 1'b1;
            end else begin
                pending_d     = cap_res_s.val[DAC_W-1:0];
                pending_sat_d = cap_res_s.clip;
            end
        end else if (clr_req_s) begin
            pending_d     = '0;
            pending_sat_d = 1'b0;
        end else begin
            pending_d     = pending_q;
            pending_sat_d = pending_sat_q;
        end
    end

    // Write sequencer next state; dac_data only changes on a launch from IDLE.
    always_comb begin
        state_d    = state_q;
        cyc_d      = cyc_q;
        dac_data_d = dac_data_q;
        dac_wr_d   = dac_wr_q;
        sat_flag_d = sat_flag_q;
        busy_inc_s = 1'b0;
        if (!fb_en) begin
            state_d  = ST_IDLE;
            cyc_d    = 4'd0;
            dac_wr_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    dac_wr_d = 1'b0;
                    cyc_d    = 4'd0;
                    if (dac_rise_s) begin
                        dac_data_d = {~out_res_s.val[DAC_W-1], out_res_s.val[DAC_W-2:0]};
                        sat_flag_d = pending_sat_q | out_res_s.clip;
                        state_d    = ST_SETUP;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_SETUP: begin
                    busy_inc_s = dac_rise_s;
                    if (cyc_q == SETUP_LAST) begin
                        state_d  = ST_STROBE;
                        cyc_d    = 4'd0;
                        dac_wr_d = 1'b1;
                    end else begin
                        cyc_d    = cyc_q + 4'd1;
                        dac_wr_d = 1'b0;
                    end
                end
                ST_STROBE: begin
                    busy_inc_s = dac_rise_s;
                    if (cyc_q == WR_LAST) begin
                        state_d  = ST_IDLE;
                        cyc_d    = 4'd0;
                        dac_wr_d = 1'b0;
                    end else begin
                        cyc_d    = cyc_q + 4'd1;
                        dac_wr_d = 1'b1;
                    end
                end
                default: begin
                    state_d  = ST_IDLE;
                    cyc_d    = 4'd0;
                    dac_wr_d = 1'b0;
                end
            endcase
        end
    end

    // Input history and pending word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fb_cond_q     <= 1'b0;
            dac_clk_q     <= 1'b0;
            store_strb_q  <= 1'b0;
            pending_q     <= '0;
            pending_sat_q <= 1'b0;
        end else begin
            fb_cond_q     <= fb_cond;
            dac_clk_q     <= dac_clk;
            store_strb_q  <= store_strb;
            pending_q     <= pending_d;
            pending_sat_q <= pending_sat_d;
        end
    end

    // Sequencer state and its registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cyc_q      <= 4'd0;
            dac_data_q <= MID_V[DAC_W-1:0];
            dac_wr_q   <= 1'b0;
            sat_flag_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cyc_q      <= cyc_d;
            dac_data_q <= dac_data_d;
            dac_wr_q   <= dac_wr_d;
            sat_flag_q <= sat_flag_d;
        end
    end

    sat_cnt #(.W(CNT_W)) u_oflow_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .inc   (oflow_inc_s),
        .cnt   (oflow_cnt)
    );

    sat_cnt #(.W(CNT_W)) u_busy_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .inc   (busy_inc_s),
        .cnt   (busy_cnt)
    );

    assign dac_data = dac_data_q;
    assign dac_wr   = dac_wr_q;
    assign sat_flag = sat_flag_q;

endmodule
